// File: rtl/modulo_counter.sv
// ---------------------------------------------------------------------------
// modulo_counter
//
// Free-running modulo-N up-counter. Once reset is released the count
// advances by one on every rising clock edge and wraps from MODULUS-1 back
// to 0. This makes it usable as a cycle/phase counter or as a divide-by-N
// timebase. A terminal-count flag marks the last state of each period, so
// downstream logic can find the wrap point without decoding the count.
//
// Parameters:
//   WIDTH    - bit width of the count output (>= 1)
//   MODULUS  - number of distinct count states, 2 <= MODULUS <= 2**WIDTH
//
// Ports:
//   clk      in   1      single clock, rising-edge active
//   rst      in   1      asynchronous, active-high reset (count -> 0)
//   count    out  WIDTH  registered counter value, 0 .. MODULUS-1
//   tc       out  1      high exactly while count == MODULUS-1
// ---------------------------------------------------------------------------
module modulo_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    // A modulus outside 2..2**WIDTH either has no wrap point or has states
    // that cannot be represented, so such a configuration is refused when
    // the design is elaborated.
    generate
        if (WIDTH < 1 || WIDTH > 62) begin : g_badWidth
            $error("modulo_counter: WIDTH must be between 1 and 62");
        end
        else if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_badModulus
            $error("modulo_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    // The last legal count value, held at the counter width so that the
    // comparison below is a plain WIDTH-bit equality.
    localparam logic [WIDTH-1:0] LAST_VALUE = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;
    logic             w_atLast;
    logic [WIDTH-1:0] w_nextCount;

    // Work out the next state. The wrap is done by an explicit compare
    // against the last value rather than by relying on binary overflow, so
    // that any modulus is handled the same way. When MODULUS equals 2**WIDTH
    // the compare and the overflow happen to coincide, and both give 0.
    always_comb begin
        w_atLast    = (r_count == LAST_VALUE);
        w_nextCount = r_count + WIDTH'(1);
        if (w_atLast) begin
            w_nextCount = '0;
        end
    end

    // The count register. Reset clears it at once, without waiting for a
    // clock edge. Counting resumes from 0 at the first rising edge at which
    // rst is seen low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end
        else begin
            r_count <= w_nextCount;
        end
    end

    // The terminal count is decoded straight from the register, with no
    // extra stage. It is therefore high during the same cycle that count
    // shows MODULUS-1, which is the cycle just before the wrap.
    assign count = r_count;
    assign tc    = w_atLast;

endmodule

// File: tb/tb_modulo_counter.sv
// ---------------------------------------------------------------------------
// tb_modulo_counter
//
// Exercises three configurations of modulo_counter side by side on a shared
// clock and reset:
//   dutA : WIDTH=4, MODULUS=10  (default, wrap at 9)
//   dutB : WIDTH=4, MODULUS=16  (full range, wrap by overflow)
//   dutC : WIDTH=1, MODULUS=2   (minimum modulus, toggles)
// Expected counts are written out by hand in a vector table. The expected
// tc for each entry is derived from that entry's expected count.
// ---------------------------------------------------------------------------
module tb_modulo_counter;

    logic       clk;
    logic       rst;
    logic [3:0] countA;
    logic       tcA;
    logic [3:0] countB;
    logic       tcB;
    logic [0:0] countC;
    logic       tcC;

    int totalChecks;
    int badChecks;

    modulo_counter #(.WIDTH(4), .MODULUS(10)) dutA (
        .clk   (clk),
        .rst   (rst),
        .count (countA),
        .tc    (tcA)
    );

    modulo_counter #(.WIDTH(4), .MODULUS(16)) dutB (
        .clk   (clk),
        .rst   (rst),
        .count (countB),
        .tc    (tcB)
    );

    modulo_counter #(.WIDTH(1), .MODULUS(2)) dutC (
        .clk   (clk),
        .rst   (rst),
        .count (countC),
        .tc    (tcC)
    );

    // The clock has a 10-unit period, and its rising edges fall at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One expected-output record for each rising edge after reset release.
    typedef struct {
        logic [3:0] expA;
        logic [3:0] expB;
        logic       expC;
    } vec_t;

    vec_t vecs[20];

    // This task compares one value and records the result. Every call counts
    // as one comparison.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d expected %0d at time %0t",
                     name, actual, expected, $time);
        end
    endtask

    // This task checks all three counters and their tc flags against one
    // set of expected counts.
    task automatic checkAll(input string tag, input logic [3:0] eA,
                            input logic [3:0] eB, input logic eC);
        checkOutput({tag, " countA"}, 32'(countA), 32'(eA));
        checkOutput({tag, " tcA"},    32'(tcA),    32'(eA == 4'd9));
        checkOutput({tag, " countB"}, 32'(countB), 32'(eB));
        checkOutput({tag, " tcB"},    32'(tcB),    32'(eB == 4'd15));
        checkOutput({tag, " countC"}, 32'(countC), 32'(eC));
        checkOutput({tag, " tcC"},    32'(tcC),    32'(eC == 1'b1));
    endtask

    // This task drives reset away from the active edge, at the falling edge.
    task automatic applyStimulus(input logic rstValue);
        @(negedge clk);
        rst = rstValue;
    endtask

    initial begin
        logic [3:0] tabA[20] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                 4'd8, 4'd9, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                                 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
        logic [3:0] tabB[20] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13,
                                 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        logic       tabC[20] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                                 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] resumeA[4] = '{4'd1, 4'd2, 4'd3, 4'd4};

        totalChecks = 0;
        badChecks   = 0;

        for (int i = 0; i < 20; i++) begin
            vecs[i].expA = tabA[i];
            vecs[i].expB = tabB[i];
            vecs[i].expC = tabC[i];
        end

        // Reset is held for two rising edges, and everything stays at zero.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkAll("reset", 4'd0, 4'd0, 1'b0);
        end

        // Reset is released and the table is walked one edge at a time.
        applyStimulus(1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            checkAll($sformatf("seq%0d", i), vecs[i].expA, vecs[i].expB,
                     vecs[i].expC);
        end

        // Six more edges bring dutA to 6: A=6, B=(20+6)%16=10, C=0.
        repeat (6) @(posedge clk);
        #1;
        checkAll("pre-midreset", 4'd6, 4'd10, 1'b0);

        // Reset is asserted between edges, and the outputs must clear
        // without any clock edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkAll("async-reset", 4'd0, 4'd0, 1'b0);

        // Reset is held across an edge and then released, and counting
        // must resume from 0.
        @(posedge clk);
        #1;
        checkAll("reset-held", 4'd0, 4'd0, 1'b0);
        applyStimulus(1'b0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checkAll($sformatf("resume%0d", k), resumeA[k], resumeA[k],
                     resumeA[k][0]);
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
